// File: rtl/maze_solve_gen_if.sv
// ---------------------------------------------------------------------------
// maze_solve_gen_if
//   Bundle between the maze solver and its environment (command processing
//   plus the navigate/heading controller).
//
//   master : the solver (drives requests, heading, status)
//   slave  : the environment (drives mode, affinity, sensors, completions)
//
//   Signals
//     cmd_md     1=command/calibration mode, 0=solve enabled
//     cmd0       affinity at start: 1=left-hand, 0=right-hand
//     lft_opn    left opening present
//     rght_opn   right opening present
//     mv_cmplt   move or heading complete pulse
//     sol_cmplt  solution (magnet) found
//     strt_mv    one-cycle move request
//     strt_hdng  one-cycle heading request
//     dsrd_hdng  registered desired heading (signed, HDNG_W bits)
//     stp_lft    stop at left opening (latched affinity = left)
//     stp_rght   stop at right opening (latched affinity = right)
//     busy       run in progress
//     done       sticky solution found
//     abort      sticky budget/watchdog abort
//     move_cnt   moves issued this run
//     state_dbg  current solver state encoding, for observation only
// ---------------------------------------------------------------------------
interface maze_solve_gen_if #(
    parameter int HDNG_W     = 12,
    parameter int MOVE_CNT_W = 8
);
    logic                  cmd_md;
    logic                  cmd0;
    logic                  lft_opn;
    logic                  rght_opn;
    logic                  mv_cmplt;
    logic                  sol_cmplt;
    logic                  strt_mv;
    logic                  strt_hdng;
    logic [HDNG_W-1:0]     dsrd_hdng;
    logic                  stp_lft;
    logic                  stp_rght;
    logic                  busy;
    logic                  done;
    logic                  abort;
    logic [MOVE_CNT_W-1:0] move_cnt;
    logic [2:0]            state_dbg;

    modport master (
        input  cmd_md, cmd0, lft_opn, rght_opn, mv_cmplt, sol_cmplt,
        output strt_mv, strt_hdng, dsrd_hdng, stp_lft, stp_rght,
               busy, done, abort, move_cnt, state_dbg
    );

    modport slave (
        output cmd_md, cmd0, lft_opn, rght_opn, mv_cmplt, sol_cmplt,
        input  strt_mv, strt_hdng, dsrd_hdng, stp_lft, stp_rght,
               busy, done, abort, move_cnt, state_dbg
    );
endinterface

// File: rtl/maze_solve_gen.sv
// ---------------------------------------------------------------------------
// maze_solve_gen
//   Wall-following maze solver. Issues forward moves and heading changes to
//   the navigate/heading controller and picks each turn from the left/right
//   opening sensors using the affinity latched at start.
//
//   Ports
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    maze_solve_gen_if.master (see interface file for signal list)
//
//   Optional build macro: MAZE_SOLVE_WATCHDOG_EN adds a cycle watchdog on
//   the two wait states; without it abort comes only from the move budget.
//
//   Handshake: strt_mv / strt_hdng are single-cycle requests with no ready;
//   the controller answers each with a single-cycle mv_cmplt pulse, which is
//   only acted on in the matching wait state (WAIT_MV / WAIT_HDNG).
// ---------------------------------------------------------------------------
module maze_solve_gen #(
    parameter int HDNG_W     = 12,
    parameter int MOVE_CNT_W = 8,
    parameter int MAX_MOVES  = 200,
    parameter int TMO_CYC    = 5000000
) (
    input logic              clk,
    input logic              rst_n,
    maze_solve_gen_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MV_FWD    = 3'd1,
        WAIT_MV   = 3'd2,
        TURN      = 3'd3,
        WAIT_HDNG = 3'd4,
        DONE      = 3'd5,
        ABORT     = 3'd6
    } state_t;

    // Heading codes for N/W/S/E in signed two's complement.
    localparam logic [HDNG_W-1:0] HDNG_N = '0;
    localparam logic [HDNG_W-1:0] HDNG_W_ = {2'b00, {(HDNG_W-2){1'b1}}};
    localparam logic [HDNG_W-1:0] HDNG_S = {1'b0, {(HDNG_W-1){1'b1}}};
    localparam logic [HDNG_W-1:0] HDNG_E = {2'b11, {(HDNG_W-2){1'b0}}};

    localparam logic [MOVE_CNT_W-1:0] MAX_CNT = MOVE_CNT_W'(MAX_MOVES);

    function automatic logic [HDNG_W-1:0] hdng_map(input logic [1:0] dir);
        case (dir)
            2'd0:    hdng_map = HDNG_N;
            2'd1:    hdng_map = HDNG_W_;
            2'd2:    hdng_map = HDNG_S;
            default: hdng_map = HDNG_E;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            dir_q, dir_turn;
    logic                  aff_q;
    logic                  stp_lft_q, stp_rght_q;
    logic [HDNG_W-1:0]     dsrd_hdng_q;
    logic                  done_q, abort_q;
    logic [MOVE_CNT_W-1:0] move_cnt_q;
    logic                  tmo;
    logic                  start;

    assign start = (state_q == IDLE) && !bus.cmd_md;

    // Watchdog: restarts on every state entry, so it measures time spent in
    // the current wait state only.
`ifdef MAZE_SOLVE_WATCHDOG_EN
    localparam int WD_W = $clog2(TMO_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYC - 1);

    logic [WD_W-1:0] wd_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else if (state_d != state_q) begin
            wd_cnt_q <= '0;
        end else if (state_q == WAIT_MV || state_q == WAIT_HDNG) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    assign tmo = (state_q == WAIT_MV || state_q == WAIT_HDNG) && (wd_cnt_q == WD_LAST);
`else
    logic unused_tmo_cyc;
    assign unused_tmo_cyc = (TMO_CYC == 0);
    assign tmo = 1'b0;
`endif

    // Turn choice: preferred side first, then the other side, else reverse.
    always_comb begin
        dir_turn = dir_q + 2'd2;
        if (aff_q) begin
            if (bus.lft_opn)       dir_turn = dir_q + 2'd1;
            else if (bus.rght_opn) dir_turn = dir_q - 2'd1;
        end else begin
            if (bus.rght_opn)      dir_turn = dir_q - 2'd1;
            else if (bus.lft_opn)  dir_turn = dir_q + 2'd1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; cmd_md cancels any active state first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!bus.cmd_md) state_d = MV_FWD;
            MV_FWD:    state_d = bus.cmd_md ? IDLE : WAIT_MV;
            WAIT_MV: begin
                if (bus.cmd_md)         state_d = IDLE;
                else if (bus.sol_cmplt) state_d = DONE;
                else if (bus.mv_cmplt)  state_d = (move_cnt_q >= MAX_CNT) ? ABORT : TURN;
                else if (tmo)           state_d = ABORT;
            end
            TURN:      state_d = bus.cmd_md ? IDLE : WAIT_HDNG;
            WAIT_HDNG: begin
                if (bus.cmd_md)         state_d = IDLE;
                else if (bus.mv_cmplt)  state_d = MV_FWD;
                else if (tmo)           state_d = ABORT;
            end
            DONE, ABORT: if (bus.cmd_md) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs; request pulses are suppressed in the cycle a cancel arrives.
    always_comb begin
        bus.strt_mv   = (state_q == MV_FWD) && !bus.cmd_md;
        bus.strt_hdng = (state_q == TURN) && !bus.cmd_md;
        bus.busy      = !(state_q == IDLE || state_q == DONE || state_q == ABORT);
        bus.state_dbg = state_q;
    end

    // Run datapath: affinity, heading, move count, sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aff_q       <= 1'b1;
            stp_lft_q   <= 1'b0;
            stp_rght_q  <= 1'b0;
            dir_q       <= 2'd0;
            dsrd_hdng_q <= '0;
            move_cnt_q  <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            if (start) begin
                aff_q       <= bus.cmd0;
                stp_lft_q   <= bus.cmd0;
                stp_rght_q  <= !bus.cmd0;
                dir_q       <= 2'd0;
                dsrd_hdng_q <= '0;
                move_cnt_q  <= '0;
                done_q      <= 1'b0;
                abort_q     <= 1'b0;
            end
            if (bus.strt_mv && (move_cnt_q != {MOVE_CNT_W{1'b1}})) begin
                move_cnt_q <= move_cnt_q + 1'b1;
            end
            if (state_q == WAIT_MV && state_d == TURN) begin
                dir_q       <= dir_turn;
                dsrd_hdng_q <= hdng_map(dir_turn);
            end
            if (state_d == DONE && state_q != DONE)   done_q  <= 1'b1;
            if (state_d == ABORT && state_q != ABORT) abort_q <= 1'b1;
        end
    end

    assign bus.dsrd_hdng = dsrd_hdng_q;
    assign bus.stp_lft   = stp_lft_q;
    assign bus.stp_rght  = stp_rght_q;
    assign bus.done      = done_q;
    assign bus.abort     = abort_q;
    assign bus.move_cnt  = move_cnt_q;

endmodule

// File: tb/tb_maze_solve_gen.sv
// ---------------------------------------------------------------------------
// tb_maze_solve_gen
//   Bench for maze_solve_gen. Instance dut runs with default parameters,
//   dut_b with a move budget of 3 and a 50-cycle watchdog limit.
//   Expected headings are pushed when a completion is driven in WAIT_MV and
//   popped by a monitor when strt_hdng appears.
// ---------------------------------------------------------------------------
module tb_maze_solve_gen;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    maze_solve_gen_if #(.HDNG_W(12), .MOVE_CNT_W(8)) a ();
    maze_solve_gen_if #(.HDNG_W(12), .MOVE_CNT_W(8)) b ();

    maze_solve_gen #(.HDNG_W(12), .MOVE_CNT_W(8), .MAX_MOVES(200), .TMO_CYC(5000000)) dut (
        .clk(clk), .rst_n(rst_n), .bus(a)
    );

    maze_solve_gen #(.HDNG_W(12), .MOVE_CNT_W(8), .MAX_MOVES(3), .TMO_CYC(50)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_q[$];
    logic [1:0]  m_d;
    bit          m_aff;

    function automatic logic [11:0] hdng_of(input logic [1:0] d);
        case (d)
            2'd0:    hdng_of = 12'h000;
            2'd1:    hdng_of = 12'h3FF;
            2'd2:    hdng_of = 12'h7FF;
            default: hdng_of = 12'hC00;
        endcase
    endfunction

    // Scoreboard sink: every heading request must match the oldest expectation.
    always @(negedge clk) begin
        logic [11:0] exp_h;
        if (rst_n === 1'b1 && a.strt_hdng === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_hdng: got dsrd_hdng=%h with no expectation", a.dsrd_hdng);
            end else begin
                exp_h = exp_q.pop_front();
                if (a.dsrd_hdng !== exp_h) begin
                    n_fail++;
                    $display("FAIL sb_dsrd_hdng: got %h want %h", a.dsrd_hdng, exp_h);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end want end of test");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic init_inputs();
        a.cmd_md = 1'b1; a.cmd0 = 1'b0; a.lft_opn = 1'b0; a.rght_opn = 1'b0;
        a.mv_cmplt = 1'b0; a.sol_cmplt = 1'b0;
        b.cmd_md = 1'b1; b.cmd0 = 1'b0; b.lft_opn = 1'b0; b.rght_opn = 1'b0;
        b.mv_cmplt = 1'b0; b.sol_cmplt = 1'b0;
    endtask

    // Returns at the negedge where strt_mv is seen (state MV_FWD).
    task automatic start_a(input bit aff, output bit ok);
        @(negedge clk);
        a.cmd0 = aff; a.cmd_md = 1'b0;
        m_aff = aff; m_d = 2'd0; ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a.strt_mv === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    // From an MV_FWD negedge: completes the move in WAIT_MV, ends in TURN.
    task automatic turn_a(input bit l, input bit r);
        @(negedge clk);
        a.lft_opn = l; a.rght_opn = r;
        if (m_aff) begin
            if (l)      m_d = m_d + 2'd1;
            else if (r) m_d = m_d - 2'd1;
            else        m_d = m_d + 2'd2;
        end else begin
            if (r)      m_d = m_d - 2'd1;
            else if (l) m_d = m_d + 2'd1;
            else        m_d = m_d + 2'd2;
        end
        exp_q.push_back(hdng_of(m_d));
        a.mv_cmplt = 1'b1;
        @(negedge clk);
        a.mv_cmplt = 1'b0;
    endtask

    // From a TURN negedge: completes the heading in WAIT_HDNG, ends in MV_FWD.
    task automatic hdng_done_a();
        @(negedge clk);
        a.mv_cmplt = 1'b1;
        @(negedge clk);
        a.mv_cmplt = 1'b0;
    endtask

    // From an MV_FWD or TURN negedge: cancel in the following wait state.
    task automatic end_run_a();
        @(negedge clk);
        a.cmd_md = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        init_inputs();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a.strt_mv, a.strt_hdng, a.stp_lft, a.stp_rght, a.busy, a.done, a.abort} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {a.strt_mv, a.strt_hdng, a.stp_lft, a.stp_rght, a.busy, a.done, a.abort});
        end
        n_checks++;
        if (a.dsrd_hdng !== 12'h000) begin n_fail++; $display("FAIL reset_hdng: got %h want 000", a.dsrd_hdng); end
        n_checks++;
        if (a.move_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", a.move_cnt); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (a.busy !== 1'b0 || a.strt_mv !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: got busy=%b strt_mv=%b want 0 0", a.busy, a.strt_mv);
        end
    endtask

    task automatic test_left_affinity();
        bit ok;
        start_a(1'b1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL left_start: got no strt_mv want strt_mv"); end
        n_checks++;
        if ({a.stp_lft, a.stp_rght, a.busy} !== 3'b101) begin
            n_fail++; $display("FAIL left_stp: got %b want 101", {a.stp_lft, a.stp_rght, a.busy});
        end
        a.cmd0 = 1'b0;  // mid-run change must be ignored
        turn_a(1'b1, 1'b1);
        n_checks++;
        if (a.strt_hdng !== 1'b1) begin n_fail++; $display("FAIL left_hdng1_lat: got %b want 1", a.strt_hdng); end
        hdng_done_a();
        n_checks++;
        if (a.strt_mv !== 1'b1) begin n_fail++; $display("FAIL left_mv_lat: got %b want 1", a.strt_mv); end
        turn_a(1'b1, 1'b0);
        n_checks++;
        if (a.strt_hdng !== 1'b1) begin n_fail++; $display("FAIL left_hdng2_lat: got %b want 1", a.strt_hdng); end
        n_checks++;
        if (a.move_cnt !== 8'd2) begin n_fail++; $display("FAIL left_cnt: got %0d want 2", a.move_cnt); end
        end_run_a();
        n_checks++;
        if (a.busy !== 1'b0) begin n_fail++; $display("FAIL left_end_busy: got %b want 0", a.busy); end
    endtask

    task automatic test_right_wrap();
        bit ok;
        start_a(1'b0, ok);
        n_checks++;
        if (!ok || {a.stp_lft, a.stp_rght} !== 2'b01) begin
            n_fail++; $display("FAIL right_start: got ok=%b stp=%b want 1 01", ok, {a.stp_lft, a.stp_rght});
        end
        turn_a(1'b0, 1'b1);
        n_checks++;
        if (a.strt_hdng !== 1'b1) begin n_fail++; $display("FAIL right_t1: got %b want 1", a.strt_hdng); end
        hdng_done_a();
        turn_a(1'b0, 1'b1);
        n_checks++;
        if (a.strt_hdng !== 1'b1) begin n_fail++; $display("FAIL right_t2: got %b want 1", a.strt_hdng); end
        hdng_done_a();
        turn_a(1'b0, 1'b0);
        n_checks++;
        if (a.strt_hdng !== 1'b1 || a.move_cnt !== 8'd3) begin
            n_fail++; $display("FAIL right_dead_end: got hdng=%b cnt=%0d want 1 3", a.strt_hdng, a.move_cnt);
        end
        end_run_a();
    endtask

    task automatic test_solution();
        bit ok;
        start_a(1'b1, ok);
        @(negedge clk);
        a.lft_opn = 1'b1; a.sol_cmplt = 1'b1; a.mv_cmplt = 1'b1;
        @(negedge clk);
        a.sol_cmplt = 1'b0; a.mv_cmplt = 1'b0;
        n_checks++;
        if ({a.done, a.abort, a.busy, a.strt_hdng} !== 4'b1000) begin
            n_fail++; $display("FAIL sol_state: got done/abort/busy/hdng=%b want 1000",
                               {a.done, a.abort, a.busy, a.strt_hdng});
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({a.done, a.busy, a.strt_mv} !== 3'b100) begin
            n_fail++; $display("FAIL sol_hold: got %b want 100", {a.done, a.busy, a.strt_mv});
        end
        a.cmd_md = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a.done !== 1'b1 || a.busy !== 1'b0) begin
            n_fail++; $display("FAIL sol_idle: got done=%b busy=%b want 1 0", a.done, a.busy);
        end
        start_a(1'b1, ok);
        n_checks++;
        if (!ok || a.done !== 1'b0) begin
            n_fail++; $display("FAIL sol_restart_clear: got ok=%b done=%b want 1 0", ok, a.done);
        end
        end_run_a();
    endtask

    task automatic test_cancel_restart();
        bit ok;
        start_a(1'b1, ok);
        turn_a(1'b1, 1'b0);
        @(negedge clk);
        a.cmd_md = 1'b1;  // cancel in WAIT_HDNG
        @(negedge clk);
        n_checks++;
        if ({a.busy, a.strt_mv, a.done, a.abort} !== 4'b0000 || a.dsrd_hdng !== 12'h3FF) begin
            n_fail++; $display("FAIL cancel_idle: got flags=%b hdng=%h want 0000 3ff",
                               {a.busy, a.strt_mv, a.done, a.abort}, a.dsrd_hdng);
        end
        start_a(1'b0, ok);
        n_checks++;
        if (!ok || {a.stp_lft, a.stp_rght} !== 2'b01 || a.dsrd_hdng !== 12'h000) begin
            n_fail++; $display("FAIL restart_swap: got ok=%b stp=%b hdng=%h want 1 01 000",
                               ok, {a.stp_lft, a.stp_rght}, a.dsrd_hdng);
        end
        @(negedge clk);
        n_checks++;
        if (a.move_cnt !== 8'd1) begin n_fail++; $display("FAIL restart_cnt: got %0d want 1", a.move_cnt); end
        a.cmd_md = 1'b1;  // cancel in WAIT_MV
        @(negedge clk);
        n_checks++;
        if ({a.busy, a.done, a.abort} !== 3'b000) begin
            n_fail++; $display("FAIL cancel_wait_mv: got %b want 000", {a.busy, a.done, a.abort});
        end
        start_a(1'b1, ok);
        a.cmd_md = 1'b1;  // cancel in MV_FWD suppresses the move request
        #1;
        n_checks++;
        if (a.strt_mv !== 1'b0) begin n_fail++; $display("FAIL cancel_mv_fwd_pulse: got %b want 0", a.strt_mv); end
        @(negedge clk);
        n_checks++;
        if (a.busy !== 1'b0 || a.move_cnt !== 8'd0) begin
            n_fail++; $display("FAIL cancel_mv_fwd: got busy=%b cnt=%0d want 0 0", a.busy, a.move_cnt);
        end
    endtask

    task automatic test_random_walk();
        bit ok, l, r, aff;
        for (int run = 0; run < 2; run++) begin
            aff = ($urandom_range(0, 1) == 1);
            start_a(aff, ok);
            for (int t = 0; t < 8; t++) begin
                l = ($urandom_range(0, 1) == 1);
                r = ($urandom_range(0, 1) == 1);
                turn_a(l, r);
                n_checks++;
                if (a.strt_hdng !== 1'b1) begin
                    n_fail++; $display("FAIL rand_hdng_req run%0d turn%0d: got %b want 1", run, t, a.strt_hdng);
                end
                hdng_done_a();
                n_checks++;
                if (a.strt_mv !== 1'b1) begin
                    n_fail++; $display("FAIL rand_mv_req run%0d turn%0d: got %b want 1", run, t, a.strt_mv);
                end
            end
            n_checks++;
            if (a.move_cnt !== 8'd8) begin n_fail++; $display("FAIL rand_cnt run%0d: got %0d want 8", run, a.move_cnt); end
            end_run_a();
        end
    endtask

    task automatic test_budget();
        @(negedge clk);
        b.cmd0 = 1'b1; b.cmd_md = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b.strt_mv !== 1'b1) begin n_fail++; $display("FAIL budget_start: got %b want 1", b.strt_mv); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            b.lft_opn = 1'b1; b.mv_cmplt = 1'b1;
            @(negedge clk);
            b.mv_cmplt = 1'b0;
            if (i < 3) begin
                n_checks++;
                if (b.strt_hdng !== 1'b1 || b.abort !== 1'b0) begin
                    n_fail++; $display("FAIL budget_turn%0d: got hdng=%b abort=%b want 1 0", i, b.strt_hdng, b.abort);
                end
                @(negedge clk);
                b.mv_cmplt = 1'b1;
                @(negedge clk);
                b.mv_cmplt = 1'b0;
            end
        end
        n_checks++;
        if ({b.abort, b.done, b.busy, b.strt_hdng} !== 4'b1000 || b.move_cnt !== 8'd3) begin
            n_fail++; $display("FAIL budget_abort: got abort/done/busy/hdng=%b cnt=%0d want 1000 3",
                               {b.abort, b.done, b.busy, b.strt_hdng}, b.move_cnt);
        end
        b.cmd_md = 1'b1;
        @(negedge clk);
        n_checks++;
        if (b.abort !== 1'b1 || b.busy !== 1'b0) begin
            n_fail++; $display("FAIL budget_sticky: got abort=%b busy=%b want 1 0", b.abort, b.busy);
        end
        b.lft_opn = 1'b0;
    endtask

`ifdef MAZE_SOLVE_WATCHDOG_EN
    task automatic test_watchdog();
        int hit;
        @(negedge clk);
        b.cmd0 = 1'b1; b.cmd_md = 1'b0;
        @(negedge clk);  // MV_FWD; next edge enters WAIT_MV
        hit = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (b.abort === 1'b1) begin hit = c; break; end
        end
        n_checks++;
        if (hit != 51) begin n_fail++; $display("FAIL wd_abort_cycle: got negedge %0d want 51", hit); end
        b.cmd_md = 1'b1;
        @(negedge clk);
    endtask
`endif

    task automatic test_async_reset();
        bit ok;
        start_a(1'b1, ok);
        turn_a(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a.strt_mv, a.strt_hdng, a.stp_lft, a.stp_rght, a.busy, a.done, a.abort} !== 7'b0
            || a.dsrd_hdng !== 12'h000 || a.move_cnt !== 8'd0) begin
            n_fail++; $display("FAIL async_reset: got flags=%b hdng=%h cnt=%0d want 0 000 0",
                               {a.strt_mv, a.strt_hdng, a.stp_lft, a.stp_rght, a.busy, a.done, a.abort},
                               a.dsrd_hdng, a.move_cnt);
        end
        init_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_left_affinity();
        test_right_wrap();
        test_solution();
        test_cancel_restart();
        test_random_walk();
        test_budget();
`ifdef MAZE_SOLVE_WATCHDOG_EN
        test_watchdog();
`endif
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
